pe_noc_interface: RTL and testbench
===================================

Name: pe_noc_interface

Overview:
- Network interface between one PE and one leaf port of the butterfly-tree NoC.
- TX path: accepts PE payload plus destination address, packs them into a flit {addr, data}, and buffers the flit in a FWFT FIFO feeding the NoC port.
- RX path: accepts flits from the NoC port through a 2-entry skid buffer, strips the address, and presents the payload to the PE.
- Flags flits delivered to the wrong PE.

Parameters:
- DataWidth, 32, payload width in bits.
- AddrWidth, 2, destination address width (numPE = 2^AddrWidth).
- MyAddr, 0, this PE's address; used for the misroute check.
- FifoDepth, 4, TX FIFO entries; power of two, ≥2.

Ports:
- i_sclk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_pe_wr_data  in  DataWidth  TX payload from PE.
- i_pe_wr_addr  in  AddrWidth  TX destination PE address.
- i_pe_wr_valid  in  1  TX payload valid.
- o_pe_wr_ready  out  1  TX FIFO can accept.
- o_noc_data  out  DataWidth+AddrWidth  flit to NoC; {addr[MSBs], data[LSBs]}.
- o_noc_data_valid  out  1  flit valid.
- i_noc_data_ready  in  1  NoC accepts flit.
- i_noc_data  in  DataWidth+AddrWidth  flit from NoC.
- i_noc_data_valid  in  1  incoming flit valid.
- o_noc_data_ready  out  1  RX buffer can accept.
- o_pe_rd_data  out  DataWidth  RX payload to PE (flit LSBs).
- o_pe_rd_valid  out  1  RX payload valid.
- i_pe_rd_ready  in  1  PE accepts payload.
- o_tx_level  out  $clog2(FifoDepth)+1  current TX FIFO occupancy.
- o_err_misroute  out  1  sticky; set when a flit with addr ≠ MyAddr is accepted.

Behaviour:

Clock and reset:
- One clock (i_sclk); reset is synchronous and active-high (i_reset).
- While i_reset=1 at a rising edge: FIFO pointers, occupancy, skid count and error flag clear.
- While i_reset=1, o_pe_wr_ready, o_noc_data_ready, o_noc_data_valid and o_pe_rd_valid are forced 0. o_tx_level reads 0 after the first reset edge. Data outputs are don't-care but must not be X after the first reset edge.
- First cycle after reset release: o_pe_wr_ready=1, o_noc_data_ready=1, both valids 0, o_err_misroute=0.
- Reset asserted mid-transfer drops all buffered flits; no partial state survives.

Handshakes:
- A transfer occurs on any valid&ready at a rising edge.
- Valid must not depend combinationally on ready.
- Once a valid is asserted, its data holds until accepted.

TX FIFO:
- Circular buffer; pointers are $clog2(FifoDepth) bits and wrap modulo FifoDepth.
- Occupancy counter runs 0..FifoDepth.
- o_pe_wr_ready = (level < FifoDepth). o_noc_data_valid = (level ≠ 0). o_noc_data = mem[rd_ptr] (FWFT).
- Push latency: a flit written at edge N is visible at o_noc_data after edge N (one cycle). There is no combinational bypass when empty.
- Push and pop on the same edge: level unchanged. This is legal at any level 1..FifoDepth-1.
- Full: no push possible, because ready=0.
- Empty: no pop, because valid=0.
- o_tx_level is the registered occupancy.

RX skid buffer:
- Two registered entries plus a count of 0..2. Head entry drives o_pe_rd_data; o_pe_rd_valid = (count ≠ 0).
- o_noc_data_ready = (count < 2), derived from the registered count only.
- Accept and deliver on the same edge: count unchanged; order preserved.
- Zero-bubble throughput: one flit per cycle sustained when i_pe_rd_ready=1.
- Misroute: on accept, if i_noc_data[DataWidth+AddrWidth-1:DataWidth] ≠ MyAddr, set o_err_misroute the next cycle. The flag is cleared only by reset. The flit is still delivered to the PE.

Optional Feature:
- Macro: PNI_STATS_EN.
- When defined, the block adds two 16-bit wrapping counters and ports:
  - o_tx_count (16, out): increments on each o_noc_data_valid & i_noc_data_ready.
  - o_rx_count (16, out): increments on each o_pe_rd_valid & i_pe_rd_ready.
  - Both reset to 0 and wrap from 16'hFFFF to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then push data=32'hA5A5_0001, addr=2'd3 with i_noc_data_ready=1 → next cycle o_noc_data=34'h3_A5A5_0001 with valid=1; o_tx_level reads 1 and then 0.
2. Hold i_noc_data_ready=0 and push 5 words with FifoDepth=4 → o_pe_wr_ready drops after the 4th accept and o_tx_level=4. Release ready → the 4 words drain in order, then the 5th is accepted. Exercises pointer wrap.
3. Stream 8 RX flits addr=MyAddr=0 back-to-back with i_pe_rd_ready=1 → 8 payloads out on consecutive cycles, o_noc_data_ready stays 1, o_err_misroute=0.
4. Hold i_pe_rd_ready=0 and offer 3 RX flits → o_noc_data_ready drops after 2 accepts. Release → payloads emerge in order with no loss or duplication.
5. Accept an RX flit with addr=2'd2 when MyAddr=0 → o_err_misroute=1 the next cycle; it stays 1 through idle cycles; pulse i_reset → 0.
6. Assert i_reset for 1 cycle with TX level=3 and RX count=2 → after the edge, level=0, both valids 0; with PNI_STATS_EN, o_tx_count and o_rx_count read 0.

Source files
------------

// File: rtl/pe_noc_interface.sv
// PE <-> butterfly-tree NoC leaf interface: TX FWFT FIFO, RX 2-entry skid buffer, misroute flag.
// Optional PNI_STATS_EN adds 16-bit wrapping TX/RX transfer counters.
module pe_noc_interface #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 2,
    parameter int unsigned MyAddr    = 0,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                           i_sclk,
    input  logic                           i_reset,
    input  logic [DataWidth-1:0]           i_pe_wr_data,
    input  logic [AddrWidth-1:0]           i_pe_wr_addr,
    input  logic                           i_pe_wr_valid,
    output logic                           o_pe_wr_ready,
    output logic [DataWidth+AddrWidth-1:0] o_noc_data,
    output logic                           o_noc_data_valid,
    input  logic                           i_noc_data_ready,
    input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
    input  logic                           i_noc_data_valid,
    output logic                           o_noc_data_ready,
    output logic [DataWidth-1:0]           o_pe_rd_data,
    output logic                           o_pe_rd_valid,
    input  logic                           i_pe_rd_ready,
    output logic [$clog2(FifoDepth):0]     o_tx_level,
    output logic                           o_err_misroute
`ifdef PNI_STATS_EN
    ,
    output logic [15:0]                    o_tx_count,
    output logic [15:0]                    o_rx_count
`endif
);

    localparam int unsigned FlitWidth = DataWidth + AddrWidth;
    localparam int unsigned PtrWidth  = $clog2(FifoDepth);
    localparam int unsigned LvlWidth  = PtrWidth + 1;

    localparam logic [LvlWidth-1:0]  LvlFull = LvlWidth'(FifoDepth);
    localparam logic [AddrWidth-1:0] OwnAddr = AddrWidth'(MyAddr);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [FlitWidth-1:0] tx_mem_q [FifoDepth];
    logic [PtrWidth-1:0]  tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PtrWidth-1:0]  tx_rd_ptr_q, tx_rd_ptr_d;
    logic [LvlWidth-1:0]  tx_level_q, tx_level_d;
    logic                 tx_push;
    logic                 tx_pop;

    // Handshake outputs come from registered state only, forced low during reset.
    always_comb begin
        o_pe_wr_ready    = ~i_reset && (tx_level_q < LvlFull);
        o_noc_data_valid = ~i_reset && (tx_level_q != '0);
        o_noc_data       = tx_mem_q[tx_rd_ptr_q];
        o_tx_level       = tx_level_q;
    end

    always_comb begin
        tx_push     = i_pe_wr_valid & o_pe_wr_ready;
        tx_pop      = o_noc_data_valid & i_noc_data_ready;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_level_d  = tx_level_q;
        if (tx_push) begin
            tx_wr_ptr_d = tx_wr_ptr_q + PtrWidth'(1);
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PtrWidth'(1);
        end
        unique case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + LvlWidth'(1);
            2'b01:   tx_level_d = tx_level_q - LvlWidth'(1);
            default: tx_level_d = tx_level_q;
        endcase
    end

    // Storage is cleared on reset so the FWFT data output is never X.
    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                tx_mem_q[i] <= '0;
            end
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_level_q  <= '0;
        end else begin
            if (tx_push) begin
                tx_mem_q[tx_wr_ptr_q] <= {i_pe_wr_addr, i_pe_wr_data};
            end
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_level_q  <= tx_level_d;
        end
    end

    // ------------------------------------------------------------------
    // RX skid buffer
    // ------------------------------------------------------------------
    logic [DataWidth-1:0] rx_ent0_q, rx_ent0_d;
    logic [DataWidth-1:0] rx_ent1_q, rx_ent1_d;
    logic [1:0]           rx_cnt_q, rx_cnt_d;
    logic                 rx_accept;
    logic                 rx_deliver;
    logic [AddrWidth-1:0] rx_addr;
    logic [DataWidth-1:0] rx_payload;
    logic                 err_misroute_q, err_misroute_d;

    always_comb begin
        o_noc_data_ready = ~i_reset && (rx_cnt_q != 2'd2);
        o_pe_rd_valid    = ~i_reset && (rx_cnt_q != 2'd0);
        o_pe_rd_data     = rx_ent0_q;
        o_err_misroute   = err_misroute_q;
    end

    always_comb begin
        rx_addr    = i_noc_data[FlitWidth-1:DataWidth];
        rx_payload = i_noc_data[DataWidth-1:0];
        rx_accept  = i_noc_data_valid & o_noc_data_ready;
        rx_deliver = o_pe_rd_valid & i_pe_rd_ready;
        rx_ent0_d  = rx_ent0_q;
        rx_ent1_d  = rx_ent1_q;
        rx_cnt_d   = rx_cnt_q;
        unique case (rx_cnt_q)
            2'd0: begin
                if (rx_accept) begin
                    rx_ent0_d = rx_payload;
                    rx_cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (rx_accept && rx_deliver) begin
                    rx_ent0_d = rx_payload;
                end else if (rx_accept) begin
                    rx_ent1_d = rx_payload;
                    rx_cnt_d  = 2'd2;
                end else if (rx_deliver) begin
                    rx_cnt_d  = 2'd0;
                end
            end
            2'd2: begin
                // Ready is low when full, so only a delivery can happen here.
                if (rx_deliver) begin
                    rx_ent0_d = rx_ent1_q;
                    rx_cnt_d  = 2'd1;
                end
            end
            default: rx_cnt_d = 2'd0;
        endcase
        err_misroute_d = err_misroute_q | (rx_accept && (rx_addr != OwnAddr));
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            rx_ent0_q      <= '0;
            rx_ent1_q      <= '0;
            rx_cnt_q       <= 2'd0;
            err_misroute_q <= 1'b0;
        end else begin
            rx_ent0_q      <= rx_ent0_d;
            rx_ent1_q      <= rx_ent1_d;
            rx_cnt_q       <= rx_cnt_d;
            err_misroute_q <= err_misroute_d;
        end
    end

    // ------------------------------------------------------------------
    // Transfer statistics
    // ------------------------------------------------------------------
`ifdef PNI_STATS_EN
    logic [15:0] tx_count_q, tx_count_d;
    logic [15:0] rx_count_q, rx_count_d;

    always_comb begin
        tx_count_d = tx_pop     ? tx_count_q + 16'd1 : tx_count_q;
        rx_count_d = rx_deliver ? rx_count_q + 16'd1 : rx_count_q;
        o_tx_count = tx_count_q;
        o_rx_count = rx_count_q;
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            tx_count_q <= 16'd0;
            rx_count_q <= 16'd0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end
`else
    // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_pe_noc_interface.sv
// Directed self-checking bench for pe_noc_interface (default parameters).
// Stats counter checks are active when PNI_STATS_EN is defined.
module tb_pe_noc_interface;

    logic        sclk;
    logic        reset;
    logic [31:0] pe_wr_data;
    logic [1:0]  pe_wr_addr;
    logic        pe_wr_valid;
    logic        pe_wr_ready;
    logic [33:0] noc_out_data;
    logic        noc_out_valid;
    logic        noc_out_ready;
    logic [33:0] noc_in_data;
    logic        noc_in_valid;
    logic        noc_in_ready;
    logic [31:0] pe_rd_data;
    logic        pe_rd_valid;
    logic        pe_rd_ready;
    logic [2:0]  tx_level;
    logic        err_misroute;
`ifdef PNI_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] rx_count;
`endif

    int checks = 0;
    int errors = 0;

    pe_noc_interface #(
        .DataWidth(32),
        .AddrWidth(2),
        .MyAddr   (0),
        .FifoDepth(4)
    ) dut (
        .i_sclk          (sclk),
        .i_reset         (reset),
        .i_pe_wr_data    (pe_wr_data),
        .i_pe_wr_addr    (pe_wr_addr),
        .i_pe_wr_valid   (pe_wr_valid),
        .o_pe_wr_ready   (pe_wr_ready),
        .o_noc_data      (noc_out_data),
        .o_noc_data_valid(noc_out_valid),
        .i_noc_data_ready(noc_out_ready),
        .i_noc_data      (noc_in_data),
        .i_noc_data_valid(noc_in_valid),
        .o_noc_data_ready(noc_in_ready),
        .o_pe_rd_data    (pe_rd_data),
        .o_pe_rd_valid   (pe_rd_valid),
        .i_pe_rd_ready   (pe_rd_ready),
        .o_tx_level      (tx_level),
        .o_err_misroute  (err_misroute)
`ifdef PNI_STATS_EN
        ,
        .o_tx_count      (tx_count),
        .o_rx_count      (rx_count)
`endif
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({pe_wr_ready, noc_in_ready, noc_out_valid, pe_rd_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_forced: actual=%b required=0000",
                     {pe_wr_ready, noc_in_ready, noc_out_valid, pe_rd_valid});
        end
        checks++;
        if (tx_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_level: actual=%0d required=0", tx_level);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({pe_wr_ready, noc_in_ready, noc_out_valid, pe_rd_valid, err_misroute} !== 5'b11000)
        begin
            errors++;
            $display("FAIL reset_release: actual=%b required=11000",
                     {pe_wr_ready, noc_in_ready, noc_out_valid, pe_rd_valid, err_misroute});
        end
        checks++;
        if ($isunknown(noc_out_data) || $isunknown(pe_rd_data)) begin
            errors++;
            $display("FAIL reset_data_x: actual=%h/%h required=known", noc_out_data, pe_rd_data);
        end
    endtask

    task automatic test_tx_single();
        noc_out_ready = 1'b1;
        pe_wr_data    = 32'hA5A5_0001;
        pe_wr_addr    = 2'd3;
        pe_wr_valid   = 1'b1;
        step();
        pe_wr_valid = 1'b0;
        checks++;
        if (noc_out_data !== 34'h3_A5A5_0001 || noc_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL tx_single_flit: actual=%h/%b required=3a5a50001/1",
                     noc_out_data, noc_out_valid);
        end
        checks++;
        if (tx_level !== 3'd1) begin
            errors++;
            $display("FAIL tx_single_level1: actual=%0d required=1", tx_level);
        end
        step();
        checks++;
        if (tx_level !== 3'd0 || noc_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_single_drain: actual=%0d/%b required=0/0", tx_level, noc_out_valid);
        end
    endtask

    task automatic test_tx_full();
        logic [2:0] exp_lvl [5];
        logic [1:0] a;
        exp_lvl[0] = 3'd4; exp_lvl[1] = 3'd3; exp_lvl[2] = 3'd3;
        exp_lvl[3] = 3'd2; exp_lvl[4] = 3'd1;
        noc_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a           = 2'(i);
            pe_wr_data  = 32'h1000_0000 + i;
            pe_wr_addr  = a;
            pe_wr_valid = 1'b1;
            checks++;
            if (pe_wr_ready !== (i < 4)) begin
                errors++;
                $display("FAIL tx_fill_ready[%0d]: actual=%b required=%b", i, pe_wr_ready, i < 4);
            end
            if (i < 4) step();
        end
        checks++;
        if (tx_level !== 3'd4) begin
            errors++;
            $display("FAIL tx_full_level: actual=%0d required=4", tx_level);
        end
        // Word 4 stays offered; it can only enter once the first drain frees a slot.
        noc_out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            a = 2'(j);
            checks++;
            if (noc_out_data !== {a, 32'h1000_0000 + j} || noc_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL tx_drain_data[%0d]: actual=%h/%b required=%h/1", j, noc_out_data,
                         noc_out_valid, {a, 32'h1000_0000 + j});
            end
            checks++;
            if (tx_level !== exp_lvl[j] || pe_wr_ready !== (j != 0)) begin
                errors++;
                $display("FAIL tx_drain_level[%0d]: actual=%0d/%b required=%0d/%b", j, tx_level,
                         pe_wr_ready, exp_lvl[j], j != 0);
            end
            step();
            if (j == 1) pe_wr_valid = 1'b0;
        end
        checks++;
        if (tx_level !== 3'd0 || noc_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_drain_empty: actual=%0d/%b required=0/0", tx_level, noc_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        pe_rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            noc_in_data  = {2'd0, 32'hB000_0000 + k};
            noc_in_valid = 1'b1;
            checks++;
            if (noc_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rx_stream_ready[%0d]: actual=%b required=1", k, noc_in_ready);
            end
            step();
            checks++;
            if (pe_rd_valid !== 1'b1 || pe_rd_data !== 32'hB000_0000 + k) begin
                errors++;
                $display("FAIL rx_stream_data[%0d]: actual=%h/%b required=%h/1", k, pe_rd_data,
                         pe_rd_valid, 32'hB000_0000 + k);
            end
        end
        noc_in_valid = 1'b0;
        step();
        checks++;
        if (pe_rd_valid !== 1'b0 || err_misroute !== 1'b0) begin
            errors++;
            $display("FAIL rx_stream_end: actual=%b/%b required=0/0", pe_rd_valid, err_misroute);
        end
    endtask

    task automatic test_rx_backpressure();
        pe_rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            noc_in_data  = {2'd0, 32'hD000_0000 + k};
            noc_in_valid = 1'b1;
            checks++;
            if (noc_in_ready !== (k < 2)) begin
                errors++;
                $display("FAIL rx_bp_ready[%0d]: actual=%b required=%b", k, noc_in_ready, k < 2);
            end
            if (k < 2) step();
        end
        pe_rd_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (pe_rd_valid !== 1'b1 || pe_rd_data !== 32'hD000_0000 + r) begin
                errors++;
                $display("FAIL rx_bp_order[%0d]: actual=%h/%b required=%h/1", r, pe_rd_data,
                         pe_rd_valid, 32'hD000_0000 + r);
            end
            checks++;
            if (noc_in_ready !== (r != 0)) begin
                errors++;
                $display("FAIL rx_bp_release_ready[%0d]: actual=%b required=%b", r,
                         noc_in_ready, r != 0);
            end
            step();
            if (r == 1) noc_in_valid = 1'b0;
        end
        checks++;
        if (pe_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_bp_empty: actual=%b required=0", pe_rd_valid);
        end
    endtask

    task automatic test_misroute();
        pe_rd_ready  = 1'b1;
        noc_in_data  = {2'd2, 32'h0000_C0DE};
        noc_in_valid = 1'b1;
        step();
        noc_in_valid = 1'b0;
        checks++;
        if (err_misroute !== 1'b1 || pe_rd_data !== 32'h0000_C0DE || pe_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL misroute_set: actual=%b/%h/%b required=1/0000c0de/1", err_misroute,
                     pe_rd_data, pe_rd_valid);
        end
        step();
        step();
        step();
        checks++;
        if (err_misroute !== 1'b1) begin
            errors++;
            $display("FAIL misroute_sticky: actual=%b required=1", err_misroute);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (err_misroute !== 1'b0) begin
            errors++;
            $display("FAIL misroute_clear: actual=%b required=0", err_misroute);
        end
    endtask

    task automatic test_reset_mid();
        noc_out_ready = 1'b0;
        pe_rd_ready   = 1'b0;
        pe_wr_valid   = 1'b1;
        noc_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pe_wr_data  = 32'hE000_0000 + i;
            pe_wr_addr  = 2'd1;
            noc_in_data = {2'd0, 32'hF000_0000 + i};
            if (i == 2) noc_in_valid = 1'b0;
            step();
        end
        pe_wr_valid = 1'b0;
        checks++;
        if (tx_level !== 3'd3 || pe_rd_valid !== 1'b1 || noc_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_preload: actual=%0d/%b/%b required=3/1/0", tx_level, pe_rd_valid,
                     noc_in_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pe_wr_ready, noc_in_ready, noc_out_valid, pe_rd_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_forced: actual=%b required=0000",
                     {pe_wr_ready, noc_in_ready, noc_out_valid, pe_rd_valid});
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (tx_level !== 3'd0 || noc_out_valid !== 1'b0 || pe_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: actual=%0d/%b/%b required=0/0/0", tx_level,
                     noc_out_valid, pe_rd_valid);
        end
`ifdef PNI_STATS_EN
        checks++;
        if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_stats: actual=%0d/%0d required=0/0", tx_count, rx_count);
        end
`endif
    endtask

    initial begin
        pe_wr_data    = '0;
        pe_wr_addr    = '0;
        pe_wr_valid   = 1'b0;
        noc_out_ready = 1'b0;
        noc_in_data   = '0;
        noc_in_valid  = 1'b0;
        pe_rd_ready   = 1'b0;
        reset         = 1'b1;
        #2;
        test_reset();
        test_tx_single();
        test_tx_full();
        test_back_to_back();
        test_rx_backpressure();
        test_misroute();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
